// File: rtl/sdr_pkg.sv
// sdr_pkg: shared constants for the SDRAM command path.
// Command encodings, arbiter states and refresh defaults.
package sdr_pkg;

  localparam logic [1:0] CMD_T_RD  = 2'b00;
  localparam logic [1:0] CMD_T_WR  = 2'b01;
  localparam logic [1:0] CMD_T_REF = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned REF_INTERVAL_DFLT = 1300;
  localparam logic [3:0]  REF_PEND_MAX      = 4'd15;

endpackage

// File: rtl/sdr_ref_timer.sv
// sdr_ref_timer: refresh interval counter and pending-refresh tally.
// Stays cleared until the controller finishes its power-up sequence.
module sdr_ref_timer
  import sdr_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = REF_INTERVAL_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       ref_ack,
  output logic [3:0] ref_pend,
  output logic       ref_overflow
);

  localparam int unsigned TW =
    (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(REF_INTERVAL - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          tick;

  assign tick = init_done && (tmr_q == TMR_LAST);

  always_comb begin
    tmr_d  = tmr_q + TW'(1);
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (!init_done) begin
      tmr_d  = '0;
      pend_d = '0;
    end else begin
      if (tick) tmr_d = '0;
      if (tick && pend_q == REF_PEND_MAX) ovf_d = 1'b1;
      // tick together with ack cancels out
      unique case (1'b1)
        tick && !ref_ack: begin
          if (pend_q != REF_PEND_MAX) pend_d = pend_q + 4'd1;
        end
        ref_ack && !tick: begin
          if (pend_q != 4'd0) pend_d = pend_q - 4'd1;
        end
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ref_pend     = pend_q;
  assign ref_overflow = ovf_q;

endmodule

// File: rtl/sdr_req_arb.sv
// sdr_req_arb: round-robin host arbiter plus refresh scheduler.
// Issues one command at a time to the SDRAM core and waits for done.
module sdr_req_arb
  import sdr_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned REF_INTERVAL = REF_INTERVAL_DFLT,
  parameter int unsigned REF_URGENT   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_done,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [1:0]               cmd_type,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [1:0]               cmd_src,
  input  logic                     cmd_done,
  output logic [3:0]               ref_pend,
  output logic                     ref_overflow
);

  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);
  localparam logic [3:0] URGENT   = 4'(REF_URGENT);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic              vld_q, vld_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        src_q, src_d;

  logic              ref_ack;
  logic              urgent;
  logic              sel_ref;
  logic              sel_req;
  logic [3:0]        valid_x;
  logic              gnt_found;
  logic [1:0]        gnt_idx;
  logic [NREQ-1:0]   gnt_oh;
  logic [ADDR_W-1:0] addr_sel;
  logic              wr_sel;

  function automatic logic [1:0] rr_idx(
    input logic [1:0]  base,
    input int unsigned off
  );
    logic [31:0] s;
    s = 32'(base) + 32'(off);
    return 2'(s % NREQ);
  endfunction

  sdr_ref_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_tmr (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .ref_ack     (ref_ack),
    .ref_pend    (ref_pend),
    .ref_overflow(ref_overflow)
  );

  assign ref_ack = vld_q && cmd_ready && (type_q == CMD_T_REF);
  assign urgent  = (ref_pend >= URGENT);

  // first valid requester after the last one granted
  always_comb begin
    valid_x   = 4'(req_valid);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!gnt_found && valid_x[rr_idx(last_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    wr_sel   = 1'b0;
    gnt_oh   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == 2'(i)) begin
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        wr_sel    = req_wr[i];
        gnt_oh[i] = 1'b1;
      end
    end
  end

  assign sel_ref = urgent || (!gnt_found && ref_pend != 4'd0);
  assign sel_req = !urgent && gnt_found;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    vld_d     = 1'b0;
    type_d    = type_q;
    addr_d    = addr_q;
    src_d     = src_q;
    req_ready = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (init_done) begin
          unique case (1'b1)
            sel_ref: begin
              type_d  = CMD_T_REF;
              addr_d  = '0;
              src_d   = '0;
              vld_d   = 1'b1;
              state_d = ARB_ISSUE;
            end
            sel_req: begin
              req_ready = gnt_oh;
              type_d    = wr_sel ? CMD_T_WR : CMD_T_RD;
              addr_d    = addr_sel;
              src_d     = gnt_idx;
              last_d    = gnt_idx;
              vld_d     = 1'b1;
              state_d   = ARB_ISSUE;
            end
            default: state_d = ARB_IDLE;
          endcase
        end
      end
      ARB_ISSUE: begin
        vld_d = 1'b1;
        if (cmd_ready) begin
          vld_d   = 1'b0;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cmd_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= LAST_RST;
      vld_q   <= 1'b0;
      type_q  <= CMD_T_RD;
      addr_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
    end
  end

  assign cmd_valid = vld_q;
  assign cmd_type  = type_q;
  assign cmd_addr  = addr_q;
  assign cmd_src   = src_q;

endmodule
